// File: rtl/clk_monitor_if.sv
// Control/result bundle for clk_monitor: enable, legal limits and measurements.
// The monitor takes the slave side; the controlling logic takes the master side.
`timescale 1ns/1ps

interface clk_monitor_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic [CNT_W-1:0] exp_period_min;
    logic [CNT_W-1:0] exp_period_max;
    logic [CNT_W-1:0] exp_high_min;
    logic [CNT_W-1:0] exp_high_max;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             period_err;
    logic             duty_err;
    logic             stuck_err;

    modport master (
        output enable, exp_period_min, exp_period_max, exp_high_min, exp_high_max,
        input  period, high_time, meas_valid, period_err, duty_err, stuck_err
    );

    modport slave (
        input  enable, exp_period_min, exp_period_max, exp_high_min, exp_high_max,
        output period, high_time, meas_valid, period_err, duty_err, stuck_err
    );
endinterface

// File: rtl/clk_monitor.sv
// Measures period and high time of an asynchronous clock in clk cycles and flags
// period, duty and stuck violations. Duty checking is built only with CLK_MON_DUTY_CHECK_EN.
`timescale 1ns/1ps

module clk_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mon_in,
    clk_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_HIGH,
        S_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic                   rise, fall;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   sat;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   period_err_q, period_err_d;
    logic                   stuck_err_q, stuck_err_d;
`ifdef CLK_MON_DUTY_CHECK_EN
    logic [CNT_W-1:0]       hold_q, hold_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic                   duty_err_q, duty_err_d;
`endif

    // Synchronizer chain: stage 0 samples mon_in, each later stage follows its predecessor.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = mon_in;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    assign edge_d = sync_q[SYNC_STAGES-1];
    assign rise   =  sync_q[SYNC_STAGES-1] & ~edge_q;
    assign fall   = ~sync_q[SYNC_STAGES-1] &  edge_q;

    assign cnt_inc = cnt_q + CNT_ONE;
    assign sat     = (cnt_inc == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        period_err_d = period_err_q;
        stuck_err_d  = stuck_err_q;
`ifdef CLK_MON_DUTY_CHECK_EN
        hold_d       = hold_q;
        high_time_d  = high_time_q;
        duty_err_d   = duty_err_q;
`endif
        if (!mon.enable) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            stuck_err_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d     = S_ARM;
                    cnt_d       = '0;
                    stuck_err_d = 1'b0;
                end
                S_ARM: begin
                    if (rise) begin
                        state_d = S_HIGH;
                        cnt_d   = CNT_ONE;
                    end else if (sat) begin
                        stuck_err_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_HIGH: begin
                    if (sat) begin
                        stuck_err_d = 1'b1;
                        state_d     = S_ARM;
                        cnt_d       = '0;
                    end else if (fall) begin
`ifdef CLK_MON_DUTY_CHECK_EN
                        hold_d  = cnt_q;
`endif
                        state_d = S_LOW;
                        cnt_d   = cnt_inc;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_LOW: begin
                    // A rise coinciding with saturation still completes the measurement.
                    if (rise) begin
                        period_d     = cnt_q;
                        meas_valid_d = 1'b1;
                        period_err_d = (cnt_q < mon.exp_period_min) || (cnt_q > mon.exp_period_max);
`ifdef CLK_MON_DUTY_CHECK_EN
                        high_time_d  = hold_q;
                        duty_err_d   = (hold_q < mon.exp_high_min) || (hold_q > mon.exp_high_max);
`endif
                        state_d      = S_HIGH;
                        cnt_d        = CNT_ONE;
                    end else if (sat) begin
                        stuck_err_d = 1'b1;
                        state_d     = S_ARM;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            edge_q       <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            period_err_q <= 1'b0;
            stuck_err_q  <= 1'b0;
`ifdef CLK_MON_DUTY_CHECK_EN
            hold_q       <= '0;
            high_time_q  <= '0;
            duty_err_q   <= 1'b0;
`endif
        end else begin
            sync_q       <= sync_d;
            edge_q       <= edge_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            period_err_q <= period_err_d;
            stuck_err_q  <= stuck_err_d;
`ifdef CLK_MON_DUTY_CHECK_EN
            hold_q       <= hold_d;
            high_time_q  <= high_time_d;
            duty_err_q   <= duty_err_d;
`endif
        end
    end

    assign mon.period     = period_q;
    assign mon.meas_valid = meas_valid_q;
    assign mon.period_err = period_err_q;
    assign mon.stuck_err  = stuck_err_q;
`ifdef CLK_MON_DUTY_CHECK_EN
    assign mon.high_time  = high_time_q;
    assign mon.duty_err   = duty_err_q;
`else
    logic unused_high_limits;
    assign unused_high_limits = ^{mon.exp_high_min, mon.exp_high_max};
    assign mon.high_time  = '0;
    assign mon.duty_err   = 1'b0;
`endif

endmodule

// File: tb/tb_clk_monitor.sv
// Randomized bench for clk_monitor: a timestamp-based reference model predicts every
// output each cycle; directed phases cover duty, period limits, stuck, enable drop and reset.
`timescale 1ns/1ps

module tb_clk_monitor;

    localparam int CW   = 8;
    localparam int SS   = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef CLK_MON_DUTY_CHECK_EN
    localparam int DUTY_ON = 1;
`else
    localparam int DUTY_ON = 0;
`endif

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic mon_in = 1'b0;

    clk_monitor_if #(.CNT_W(CW)) bus ();

    clk_monitor #(
        .CNT_W       (CW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mon_in (mon_in),
        .mon    (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitored clock generator: mon_hi cycles high then mon_lo cycles low, changes on negedge.
    int mon_hi  = 5;
    int mon_lo  = 5;
    bit mon_run = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_run) begin
                mon_in = 1'b0;
            end else begin
                mon_in = 1'b1;
                repeat (mon_hi) @(negedge clk);
                mon_in = 1'b0;
                repeat (mon_lo - 1) @(negedge clk);
            end
        end
    end

    // Reference model: edges seen through a fixed latency, measurements from edge timestamps.
    int          cyc = 0;
    logic [SS+1:0] hist = '0;
    bit          en_prev = 1'b0;
    bit          have_rise = 1'b0;
    int          t_rise = 0, t_fall = 0, origin = 0;
    bit          m_rise, m_fall;
    int          m_p, m_h;
    int          e_period = 0, e_high = 0;
    bit          e_mv = 1'b0, e_perr = 1'b0, e_derr = 1'b0, e_stuck = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                hist      = '0;
                en_prev   = 1'b0;
                have_rise = 1'b0;
                e_period  = 0;
                e_high    = 0;
                e_mv      = 1'b0;
                e_perr    = 1'b0;
                e_derr    = 1'b0;
                e_stuck   = 1'b0;
            end else begin
                cyc++;
                hist   = {hist[SS:0], mon_in};
                m_rise = hist[SS] & ~hist[SS+1];
                m_fall = ~hist[SS] & hist[SS+1];
                e_mv   = 1'b0;
                if (!bus.enable) begin
                    e_stuck   = 1'b0;
                    have_rise = 1'b0;
                end else if (!en_prev) begin
                    e_stuck   = 1'b0;
                    have_rise = 1'b0;
                    origin    = cyc;
                end else if (m_rise) begin
                    if (have_rise) begin
                        m_p      = cyc - t_rise;
                        m_h      = t_fall - t_rise;
                        e_period = m_p;
                        e_perr   = (m_p < int'(bus.exp_period_min)) || (m_p > int'(bus.exp_period_max));
                        if (DUTY_ON != 0) begin
                            e_high = m_h;
                            e_derr = (m_h < int'(bus.exp_high_min)) || (m_h > int'(bus.exp_high_max));
                        end
                        e_mv = 1'b1;
                    end
                    have_rise = 1'b1;
                    t_rise    = cyc;
                    origin    = cyc - 1;
                end else if (cyc - origin == CMAX) begin
                    e_stuck   = 1'b1;
                    have_rise = 1'b0;
                    origin    = cyc;
                end else if (m_fall) begin
                    t_fall = cyc;
                end
                en_prev = bus.enable;
            end
        end
    end

    // Per-cycle comparison of every output against the model, sampled mid-cycle.
    bit chk_on = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                if (bus.meas_valid)
                    $display("meas t=%0t period=%0d high=%0d perr=%0b derr=%0b stuck=%0b",
                             $time, bus.period, bus.high_time, bus.period_err, bus.duty_err, bus.stuck_err);
                chk("meas_valid", 32'(bus.meas_valid), 32'(e_mv));
                chk("period",     32'(bus.period),     32'(e_period));
                chk("high_time",  32'(bus.high_time),  32'(e_high));
                chk("period_err", 32'(bus.period_err), 32'(e_perr));
                chk("duty_err",   32'(bus.duty_err),   32'(e_derr));
                chk("stuck_err",  32'(bus.stuck_err),  32'(e_stuck));
            end
        end
    end

    task automatic set_limits(input int pmin, input int pmax, input int hmin, input int hmax);
        bus.exp_period_min = CW'(pmin);
        bus.exp_period_max = CW'(pmax);
        bus.exp_high_min   = CW'(hmin);
        bus.exp_high_max   = CW'(hmax);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"},     32'(bus.period),     0);
        chk({tag, "_high_time"},  32'(bus.high_time),  0);
        chk({tag, "_meas_valid"}, 32'(bus.meas_valid), 0);
        chk({tag, "_period_err"}, 32'(bus.period_err), 0);
        chk({tag, "_duty_err"},   32'(bus.duty_err),   0);
        chk({tag, "_stuck_err"},  32'(bus.stuck_err),  0);
    endtask

    initial begin
        bus.enable = 1'b0;
        set_limits(8, 12, 4, 6);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // 5/5 clock, all within limits
        mon_hi = 5; mon_lo = 5; mon_run = 1'b1;
        bus.enable = 1'b1;
        repeat (60) @(negedge clk);
        chk("dir_period10", 32'(bus.period), 10);
        chk("dir_high5",    32'(bus.high_time), 32'(5 * DUTY_ON));
        chk("dir_perr0",    32'(bus.period_err), 0);
        chk("dir_derr0",    32'(bus.duty_err), 0);

        // 3/7 clock: duty violation only
        mon_hi = 3; mon_lo = 7;
        repeat (60) @(negedge clk);
        chk("dir_high3",    32'(bus.high_time), 32'(3 * DUTY_ON));
        chk("dir_derr1",    32'(bus.duty_err), 32'(DUTY_ON));
        chk("dir_perr_ok",  32'(bus.period_err), 0);

        // 10/10 clock: period violation, then widened limits clear it
        mon_hi = 10; mon_lo = 10;
        repeat (80) @(negedge clk);
        chk("dir_period20", 32'(bus.period), 20);
        chk("dir_perr1",    32'(bus.period_err), 1);
        set_limits(18, 22, 8, 12);
        repeat (45) @(negedge clk);
        chk("dir_perr_clr", 32'(bus.period_err), 0);

        // enable dropped while mon_in is high
        for (int i = 0; i < 40 && mon_in !== 1'b1; i++) @(negedge clk);
        chk("wait_mon_high", 32'(mon_in), 1);
        repeat (2) @(negedge clk);
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop_keep_period", 32'(bus.period), 20);
        bus.enable = 1'b1;
        repeat (60) @(negedge clk);

        // stuck: mon_in held low after a fresh enable
        mon_run = 1'b0;
        repeat (25) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;
        repeat (255) @(negedge clk);
        chk("stuck_not_yet", 32'(bus.stuck_err), 0);
        @(negedge clk);
        chk("stuck_at_255", 32'(bus.stuck_err), 1);
        repeat (20) @(negedge clk);
        chk("stuck_sticky", 32'(bus.stuck_err), 1);
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("stuck_cleared", 32'(bus.stuck_err), 0);

        // asynchronous reset in the low phase
        set_limits(8, 12, 4, 6);
        mon_hi = 5; mon_lo = 5; mon_run = 1'b1;
        bus.enable = 1'b1;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 40 && mon_in !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 40 && mon_in !== 1'b0; i++) @(negedge clk);
        chk("wait_mon_low", 32'(mon_in), 0);
        @(negedge clk);
        chk("pre_rst_period", 32'(bus.period), 10);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("post_rst_period", 32'(bus.period), 10);

        // randomized clocks, limits and enable drops
        for (int r = 0; r < 25; r++) begin
            int pmin, hmin;
            mon_hi = $urandom_range(2, 14);
            mon_lo = $urandom_range(2, 14);
            pmin   = $urandom_range(3, 20);
            hmin   = $urandom_range(1, 10);
            set_limits(pmin, pmin + $urandom_range(0, 10), hmin, hmin + $urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) begin
                bus.enable = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                bus.enable = 1'b1;
            end
            repeat ($urandom_range(20, 70)) @(negedge clk);
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
